// File: rtl/sb_dec_pkg.sv
// Shared definitions for the masked decryption S-box input path:
// column geometry, inverse-affine constant, serializer FSM states and
// the bit-sliced share indexing helper.
package sb_dec_pkg;

    localparam int         BYTES_PER_COL = 4;
    localparam logic [7:0] INV_AFF_CONST = 8'h05;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SER  = 1'b1
    } ser_state_e;

    // Position of share 'share' of bit 'bit_idx' on a bit-sliced bus
    // where the n_shares shares of one bit sit next to each other.
    function automatic int bit_pos(input int bit_idx, input int share, input int n_shares);
        return bit_idx * n_shares + share;
    endfunction

endpackage

// File: rtl/msk_inv_affine.sv
// Share-wise AES inverse affine map on a bit-sliced masked byte.
// Each output share depends only on the same share of the input, so no
// gate ever mixes two shares of one bit. The constant is folded into
// share 0 only, which keeps the XOR of all shares equal to InvAff(x).
module msk_inv_affine
    import sb_dec_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [8*d-1:0] x_i,
    output logic [8*d-1:0] y_o
);

    genvar gi, gj;
    generate
        for (gi = 0; gi < d; gi++) begin : g_share
            for (gj = 0; gj < 8; gj++) begin : g_bit
                localparam logic CBIT = (gi == 0) ? INV_AFF_CONST[gj] : 1'b0;
                // y_j = x_(j+2) ^ x_(j+5) ^ x_(j+7), all within share gi
                assign y_o[bit_pos(gj, gi, d)] = x_i[bit_pos((gj + 2) % 8, gi, d)]
                                               ^ x_i[bit_pos((gj + 5) % 8, gi, d)]
                                               ^ x_i[bit_pos((gj + 7) % 8, gi, d)]
                                               ^ CBIT;
            end
        end
    endgenerate

endmodule

// File: rtl/sb_inv_affine_serializer.sv
// Masked column serializer: latches one d-share 32-bit column and hands
// it byte by byte (after the share-wise inverse affine map) to the masked
// GF(2^8) inversion core using a valid/ready handshake. A new column can
// be taken in the same cycle the last byte of the current one leaves.
module sb_inv_affine_serializer
    import sb_dec_pkg::*;
#(
    parameter int d = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            col_valid,
    output logic            col_ready,
    input  logic [32*d-1:0] col_data,
    output logic            byte_valid,
    input  logic            byte_ready,
    output logic [8*d-1:0]  byte_data,
    output logic [1:0]      byte_idx,
    output logic            byte_last
);

    ser_state_e      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [32*d-1:0] col_q, col_d;

    logic [8*d-1:0]  col_bytes [BYTES_PER_COL];
    logic [8*d-1:0]  byte_sel;

    // Split the column register into its bit-sliced bytes
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_COL; gi++) begin : g_byte
            assign col_bytes[gi] = col_q[gi*8*d +: 8*d];
        end
    endgenerate

    assign byte_sel = col_bytes[cnt_q];

    // Inverse affine runs on registered data, so outputs stay stable under backpressure
    msk_inv_affine #(
        .d(d)
    ) u_inv_aff (
        .x_i(byte_sel),
        .y_o(byte_data)
    );

    assign byte_idx  = cnt_q;
    assign byte_last = (state_q == ST_SER) && (cnt_q == 2'd3);

    // Next-state, counter, column capture and handshake outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        col_ready  = 1'b0;
        byte_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                col_ready = 1'b1;
                if (col_valid) begin
                    col_d   = col_data;
                    cnt_d   = 2'd0;
                    state_d = ST_SER;
                end
            end
            ST_SER: begin
                byte_valid = 1'b1;
                if (byte_ready) begin
                    if (cnt_q == 2'd3) begin
                        col_ready = 1'b1;
                        cnt_d     = 2'd0;
                        if (col_valid) begin
                            col_d = col_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State registers; reset drops any partial column immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: tb/tb_sb_inv_affine_serializer.sv
// Scoreboard bench for sb_inv_affine_serializer with three shares:
// directed known-answer, masking, backpressure, back-to-back, reset and
// random backpressure runs against a bit-level inverse affine model.
module tb_sb_inv_affine_serializer;

    localparam int D    = 3;
    localparam int NCOL = 3000;

    logic            clk;
    logic            rst_n;
    logic            col_valid;
    logic            col_ready;
    logic [32*D-1:0] col_data;
    logic            byte_valid;
    logic            byte_ready;
    logic [8*D-1:0]  byte_data;
    logic [1:0]      byte_idx;
    logic            byte_last;

    typedef struct {
        logic [8*D-1:0] data;
        logic [7:0]     plain;
        logic [1:0]     idx;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic verbose = 1'b1;
    logic rand_bp = 1'b0;

    sb_inv_affine_serializer #(
        .d(D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .col_data  (col_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_data (byte_data),
        .byte_idx  (byte_idx),
        .byte_last (byte_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [7:0] inv_aff8(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
        return y;
    endfunction

    function automatic logic [7:0] share_byte(input logic [32*D-1:0] c, input int b, input int s);
        logic [7:0] y;
        for (int j = 0; j < 8; j++) y[j] = c[(8*b + j)*D + s];
        return y;
    endfunction

    function automatic logic [7:0] out_share(input logic [8*D-1:0] v, input int s);
        logic [7:0] y;
        for (int j = 0; j < 8; j++) y[j] = v[j*D + s];
        return y;
    endfunction

    function automatic logic [7:0] unmask(input logic [8*D-1:0] v);
        logic [7:0] y;
        y = 8'h00;
        for (int s = 0; s < D; s++) y ^= out_share(v, s);
        return y;
    endfunction

    function automatic logic [8*D-1:0] exp_vec(input logic [32*D-1:0] c, input int b);
        logic [8*D-1:0] v;
        logic [7:0]     t;
        v = '0;
        for (int s = 0; s < D; s++) begin
            t = inv_aff8(share_byte(c, b, s)) ^ ((s == 0) ? 8'h05 : 8'h00);
            for (int j = 0; j < 8; j++) v[j*D + s] = t[j];
        end
        return v;
    endfunction

    function automatic logic [32*D-1:0] pack_col(input logic [D-1:0][31:0] sh);
        logic [32*D-1:0] c;
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 8; j++)
                for (int s = 0; s < D; s++) c[(8*b + j)*D + s] = sh[s][8*b + j];
        return c;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: push expected bytes on column accept, pop on byte transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid && byte_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (verbose)
                        $display("[TB] byte idx=%0d data=%h plain=%h last=%0b",
                                 byte_idx, byte_data, unmask(byte_data), byte_last);
                    chk("byte_data", 64'(byte_data), 64'(e.data));
                    chk("byte_idx", 64'(byte_idx), 64'(e.idx));
                    chk("byte_last", 64'(byte_last), 64'(e.idx == 2'd3));
                    chk("unmasked", 64'(unmask(byte_data)), 64'(e.plain));
                end
            end
            if (col_valid && col_ready) begin
                for (int b = 0; b < 4; b++) begin
                    exp_t e;
                    logic [7:0] p;
                    p = 8'h00;
                    for (int s = 0; s < D; s++) p ^= share_byte(col_data, b, s);
                    e.data  = exp_vec(col_data, b);
                    e.plain = inv_aff8(p) ^ 8'h05;
                    e.idx   = 2'(b);
                    sb.push_back(e);
                end
            end
        end
    end

    // Random downstream backpressure
    always @(posedge clk) begin
        if (rand_bp) begin
            #1 byte_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_col(input logic [32*D-1:0] c);
        int t;
        @(posedge clk);
        #1;
        col_valid = 1'b1;
        col_data  = c;
        t = 0;
        @(negedge clk);
        while (!col_ready) begin
            t++;
            if (t > 1000) begin
                chk("col_accept_timeout", 64'd1, 64'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        col_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        @(negedge clk);
        while (sb.size() != 0 || byte_valid) begin
            t++;
            if (t > 1000) begin
                chk("drain_timeout", 64'(sb.size()), 64'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    logic [D-1:0][31:0] sh;
    logic [7:0]         plain_tab [4];
    logic [32*D-1:0]    col_a, col_b;
    logic [31:0]        r;

    initial begin
        plain_tab[0] = 8'hA7;   // 0x52
        plain_tab[1] = 8'h05;   // 0x00
        plain_tab[2] = 8'h00;   // 0x63
        plain_tab[3] = 8'h01;   // 0x7C
        rst_n      = 1'b0;
        col_valid  = 1'b0;
        col_data   = '0;
        byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_byte_valid", 64'(byte_valid), 64'd0);
        chk("rst_col_ready", 64'(col_ready), 64'd1);
        chk("rst_byte_idx", 64'(byte_idx), 64'd0);
        chk("rst_byte_last", 64'(byte_last), 64'd0);

        // Known-answer column, unshared
        byte_ready = 1'b1;
        sh = '0;
        sh[0] = 32'h7C630052;
        send_col(pack_col(sh));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("kat_valid", 64'(byte_valid), 64'd1);
            chk("kat_idx", 64'(byte_idx), 64'(i));
            chk("kat_plain", 64'(unmask(byte_data)), 64'(plain_tab[i]));
        end
        @(negedge clk);
        chk("kat_idle_after", 64'(byte_valid), 64'd0);
        wait_drain();

        // Same column masked with random share 1
        r = $urandom();
        sh = '0;
        sh[0] = 32'h7C630052 ^ r;
        sh[1] = r;
        send_col(pack_col(sh));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("msk_idx", 64'(byte_idx), 64'(i));
            chk("msk_plain", 64'(unmask(byte_data)), 64'(plain_tab[i]));
            chk("msk_share1", 64'(out_share(byte_data, 1)), 64'(inv_aff8(r[8*i +: 8])));
        end
        wait_drain();

        // Backpressure for 3 cycles while idx1 is presented
        sh[0] = $urandom(); sh[1] = $urandom(); sh[2] = $urandom();
        col_a = pack_col(sh);
        send_col(col_a);
        @(posedge clk);
        #1 byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_idx", 64'(byte_idx), 64'd1);
            chk("bp_data", 64'(byte_data), 64'(exp_vec(col_a, 1)));
            chk("bp_valid", 64'(byte_valid), 64'd1);
            chk("bp_col_ready", 64'(col_ready), 64'd0);
        end
        @(posedge clk);
        #1 byte_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("bp_resume_idx", 64'(byte_idx), 64'(i));
        end
        wait_drain();

        // Two columns back to back with col_valid held high
        sh[0] = $urandom(); sh[1] = $urandom(); sh[2] = $urandom();
        col_a = pack_col(sh);
        sh[0] = $urandom(); sh[1] = $urandom(); sh[2] = $urandom();
        col_b = pack_col(sh);
        @(posedge clk);
        #1;
        col_valid = 1'b1;
        col_data  = col_a;
        @(negedge clk);
        chk("b2b_first_ready", 64'(col_ready), 64'd1);
        @(posedge clk);
        #1 col_data = col_b;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_a_valid", 64'(byte_valid), 64'd1);
            chk("b2b_a_idx", 64'(byte_idx), 64'(i));
            chk("b2b_a_col_ready", 64'(col_ready), 64'(i == 3));
        end
        @(posedge clk);
        #1 col_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_b_valid", 64'(byte_valid), 64'd1);
            chk("b2b_b_idx", 64'(byte_idx), 64'(i));
            chk("b2b_b_col_ready", 64'(col_ready), 64'(i == 3));
        end
        @(negedge clk);
        chk("b2b_idle_after", 64'(byte_valid), 64'd0);
        wait_drain();

        // Reset while idx2 is on the output
        sh[0] = $urandom(); sh[1] = $urandom(); sh[2] = $urandom();
        send_col(pack_col(sh));
        repeat (3) @(negedge clk);
        chk("rst_mid_idx", 64'(byte_idx), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(byte_valid), 64'd0);
        chk("rst_mid_col_ready", 64'(col_ready), 64'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rel_idx", 64'(byte_idx), 64'd0);
        sh[0] = $urandom(); sh[1] = $urandom(); sh[2] = $urandom();
        send_col(pack_col(sh));
        @(negedge clk);
        chk("rst_new_valid", 64'(byte_valid), 64'd1);
        chk("rst_new_idx", 64'(byte_idx), 64'd0);
        wait_drain();

        // Random columns with random backpressure
        verbose = 1'b0;
        rand_bp = 1'b1;
        for (int n = 0; n < NCOL; n++) begin
            sh[0] = $urandom(); sh[1] = $urandom(); sh[2] = $urandom();
            send_col(pack_col(sh));
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2 byte_ready = 1'b1;
        wait_drain();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
